// File: rtl/dp_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dp_sweep_ctrl
//
// Sequencer for a small combinational code-to-word datapath. It walks an
// input code from `first` to `last` inclusive, waits SETTLE cycles at each
// code, captures the datapath output, and offers one (code, data) result per
// step on a valid/ready stream. A running XOR checksum covers every result
// accepted in the current sweep.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep (sampled only in IDLE)
//   first      in   first code, sampled with start
//   last       in   last code (inclusive), sampled with start
//   dp_in      out  code driven to the datapath (registered)
//   dp_out     in   datapath result, combinational function of dp_in
//   res_valid  out  result available
//   res_ready  in   consumer accepts the result
//   res_code   out  code the result belongs to
//   res_data   out  captured dp_out
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at the end of a sweep
//   checksum   out  XOR of all res_data accepted in the current sweep
// ---------------------------------------------------------------------------
module dp_sweep_ctrl #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  first,
    input  logic [IN_W-1:0]  last,
    output logic [IN_W-1:0]  dp_in,
    input  logic [OUT_W-1:0] dp_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IN_W-1:0]  res_code,
    output logic [OUT_W-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] checksum
);

    localparam int CNT_W = 4;  // holds SETTLE in 0..15
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  last_q;

    // One-cycle action strobes decoded alongside the next state.
    logic go;       // valid range accepted, begin stepping
    logic skip;     // empty range (first > last), straight to FIN
    logic capture;  // settle time elapsed, snapshot the datapath
    logic xfer;     // result handshake completes on this edge

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        go       = 1'b0;
        skip     = 1'b0;
        capture  = 1'b0;
        xfer     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (first <= last) begin
                        go       = 1'b1;
                        state_nx = DRIVE;
                    end else begin
                        skip     = 1'b1;
                        state_nx = FIN;
                    end
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    xfer = 1'b1;
                    // Equality against last, never increment-and-compare, so
                    // last = all-ones terminates without wrapping to zero.
                    state_nx = (res_code == last_q) ? FIN : DRIVE;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign res_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_in    <= '0;
            last_q   <= '0;
            cnt      <= '0;
            res_code <= '0;
            res_data <= '0;
            checksum <= '0;
        end else begin
            if (go) begin
                last_q   <= last;
                dp_in    <= first;
                cnt      <= SETTLE_C;
                checksum <= '0;
            end
            if (skip) begin
                checksum <= '0;
            end
            if (state == DRIVE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                res_code <= dp_in;
                res_data <= dp_out;
            end
            if (xfer) begin
                checksum <= checksum ^ res_data;
                if (res_code != last_q) begin
                    dp_in <= dp_in + 1'b1;
                    cnt   <= SETTLE_C;
                end
            end
        end
    end

endmodule

// File: tb/tb_dp_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dp_sweep_ctrl
//
// Bench for dp_sweep_ctrl with a datapath model dp_out = {8{dp_in}} and
// SETTLE = 2. Expected (code, data) pairs are queued when a sweep is
// launched and popped as the DUT offers results. Outputs are sampled on the
// falling clock edge; inputs are driven there as well.
// ---------------------------------------------------------------------------
module tb_dp_sweep_ctrl;

    localparam int IN_W   = 4;
    localparam int OUT_W  = 32;
    localparam int SETTLE = 2;
    localparam int BUDGET = 400;

    typedef struct packed {
        logic [IN_W-1:0]  code;
        logic [OUT_W-1:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [IN_W-1:0]  first;
    logic [IN_W-1:0]  last;
    logic [IN_W-1:0]  dp_in;
    logic [OUT_W-1:0] dp_out;
    logic             res_valid;
    logic             res_ready;
    logic [IN_W-1:0]  res_code;
    logic [OUT_W-1:0] res_data;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] checksum;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    dp_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first     (first),
        .last      (last),
        .dp_in     (dp_in),
        .dp_out    (dp_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_code  (res_code),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    // Datapath model.
    assign dp_out = {8{dp_in}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one sweep, consume its results and check them against the
    // scoreboard. stall = number of cycles res_ready is held low per result.
    // poke_start re-pulses start (with different bounds) while busy.
    task automatic run_sweep(input logic [IN_W-1:0] f, input logic [IN_W-1:0] l,
                             input int stall, input bit poke_start, input string tag);
        int          k;
        int          stalled;
        int          first_valid_k;
        int          done_k;
        int          busy_bad;
        int          exp_valid_k;
        bit          finished;
        logic [OUT_W-1:0] csum;
        logic [IN_W-1:0]  c4;
        exp_t        e;

        csum = '0;
        for (int c = int'(f); c <= int'(l); c++) begin
            c4     = IN_W'(c);
            e.code = c4;
            e.data = {8{c4}};
            sb.push_back(e);
            csum   = csum ^ e.data;
        end

        @(negedge clk);
        start     = 1'b1;
        first     = f;
        last      = l;
        res_ready = (stall == 0);
        @(negedge clk);
        start         = 1'b0;
        k             = 0;
        stalled       = 0;
        first_valid_k = -1;
        done_k        = -1;
        busy_bad      = 0;
        finished      = 1'b0;

        while (!finished && k < BUDGET) begin
            if (poke_start && k == 1) begin
                start = 1'b1;
                first = 4'h0;
                last  = 4'hF;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_bad++;
            if (res_valid === 1'b1) begin
                if (first_valid_k < 0) first_valid_k = k;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s extra_result: code=%h data=%h, none expected",
                             tag, res_code, res_data);
                    res_ready = 1'b1;
                end else begin
                    e = sb[0];
                    checks++;
                    if (res_code !== e.code || res_data !== e.data) begin
                        errors++;
                        $display("FAIL %s result: got code=%h data=%h, want code=%h data=%h",
                                 tag, res_code, res_data, e.code, e.data);
                    end
                    checks++;
                    if (dp_in !== e.code) begin
                        errors++;
                        $display("FAIL %s dp_in_hold: got %h, want %h", tag, dp_in, e.code);
                    end
                    if (stalled < stall) begin
                        res_ready = 1'b0;
                        stalled++;
                    end else begin
                        res_ready = 1'b1;
                        void'(sb.pop_front());
                        stalled = 0;
                    end
                end
            end else begin
                res_ready = (stall == 0);
            end
            if (done === 1'b1) begin
                done_k   = k;
                finished = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, BUDGET);
        end

        // Cycle after the done pulse: back in IDLE.
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b, want 0 0", tag, done, busy);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_span: got %0d low cycles, want 0", tag, busy_bad);
        end
        exp_valid_k = (f <= l) ? SETTLE + 1 : -1;
        checks++;
        if (first_valid_k != exp_valid_k) begin
            errors++;
            $display("FAIL %s first_valid: got cycle %0d, want %0d", tag, first_valid_k, exp_valid_k);
        end
        if (f > l) begin
            checks++;
            if (done_k != 0) begin
                errors++;
                $display("FAIL %s empty_done: got cycle %0d, want 0", tag, done_k);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing_results: got %0d left, want 0", tag, sb.size());
            sb.delete();
        end
        checks++;
        if (checksum !== csum) begin
            errors++;
            $display("FAIL %s checksum: got %h, want %h", tag, checksum, csum);
        end
        // Checksum must hold in IDLE.
        repeat (2) @(negedge clk);
        checks++;
        if (checksum !== csum || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s checksum_hold: got %h busy=%b, want %h busy=0",
                     tag, checksum, busy, csum);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (dp_in !== '0 || res_valid !== 1'b0 || res_code !== '0 || res_data !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || checksum !== '0) begin
            errors++;
            $display("FAIL %s outputs: got dp_in=%h v=%b code=%h data=%h busy=%b done=%b csum=%h, want all 0",
                     tag, dp_in, res_valid, res_code, res_data, busy, done, checksum);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        first     = '0;
        last      = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_release");
    endtask

    task automatic test_full_sweep();
        run_sweep(4'h0, 4'hF, 0, 1'b0, "full_sweep");
    endtask

    task automatic test_partial_sweep();
        run_sweep(4'h3, 4'h5, 0, 1'b0, "partial_sweep");
    endtask

    task automatic test_backpressure();
        run_sweep(4'h7, 4'h8, 5, 1'b0, "backpressure");
    endtask

    task automatic test_edge_ranges();
        run_sweep(4'h9, 4'h2, 0, 1'b0, "empty_range");
        run_sweep(4'hF, 4'hF, 0, 1'b0, "single_max");
    endtask

    task automatic test_start_while_busy();
        run_sweep(4'h3, 4'h5, 0, 1'b1, "start_busy");
    endtask

    task automatic test_reset_mid_sweep();
        int  n;
        bit  seen;
        @(negedge clk);
        start     = 1'b1;
        first     = 4'h0;
        last      = 4'hF;
        res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        n     = 0;
        while (!seen && n < 20) begin
            if (res_valid === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid wait_valid: got no res_valid in 20 cycles, want EMIT");
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_release");
        run_sweep(4'h0, 4'h1, 0, 1'b0, "after_reset");
        checks++;
        if (checksum !== 32'h1111_1111) begin
            errors++;
            $display("FAIL after_reset checksum_const: got %h, want 11111111", checksum);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_partial_sweep();
        test_backpressure();
        test_edge_ranges();
        test_start_while_busy();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
